module_alu_shift_seq: RTL and testbench
=======================================

Name: module_alu_shift_seq

Overview:
Parametrised, sequential successor to the team's combinational ALU shift-right unit. It supports four shift/rotate modes, a selectable fill bit, carry-out and zero flags, and a start/ready/valid handshake. The default build shifts one bit position per clock; an optional single-cycle barrel path can be compiled in. It sits in the ALU datapath beside the arithmetic units and drives ALUResult_o into the result mux.

Parameters:
WIDTH, 8, operand/result data width; must be a power of two and at least 2
CNT_W, $clog2(WIDTH)+1, width of the shift-amount input (derived; not overridden by users)

Ports:
clk_i  input  1  system clock; all state updates on the rising edge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  request; accepted only in a cycle where ready_o=1
ALUA_i  input  WIDTH  operand to shift
ALUB_i  input  CNT_W  shift amount, unsigned
ALUFlagIn_i  input  1  fill bit for logical shifts (0 = zeros, 1 = ones)
ALUMode_i  input  2  00 SHL, 01 SHR, 10 ROL, 11 ROR
ready_o  output  1  high in IDLE
valid_o  output  1  one-cycle pulse: result is complete
ALUResult_o  output  WIDTH+1  {carry, result}; held until the next accepted start
ALUZero_o  output  1  result field == 0; updated with ALUResult_o

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge): FSM goes to IDLE; ready_o=1, valid_o=0, ALUResult_o=0, ALUZero_o=1, internal regs cleared. Reset wins over start_i in the same cycle. Reset mid-operation aborts it; no valid_o pulse follows.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start_i=1, capture ALUA_i, mode, fill and effective count k.
  - k>0 -> SHIFT; k=0 -> DONE.
- Effective count k:
  - SHL/SHR: k = min(ALUB_i, WIDTH). Amounts above WIDTH saturate.
  - ROL/ROR: k = ALUB_i mod WIDTH.
- SHIFT: one-position step per cycle, down-counter decrements; leave for DONE when the counter reaches 0 after the k-th step.
  - SHL: data <= {data[W-2:0], fill}; carry <= data[W-1].
  - SHR: data <= {fill, data[W-1:1]}; carry <= data[0].
  - ROL: data <= {data[W-2:0], data[W-1]}; carry <= data[W-1].
  - ROR: data <= {data[0], data[W-1:1]}; carry <= data[0].
- Carry: equals the last bit shifted or rotated out. It is 0 when k=0 and is cleared at capture.
- DONE:
  - Lasts exactly one cycle, with valid_o=1 and ALUResult_o/ALUZero_o updated; then -> IDLE.
  - ready_o=0 in SHIFT and DONE.
- Latency: valid_o is high in cycle N+k+1, where start_i was accepted in cycle N. Total occupancy is k+2 cycles including the accept cycle.
- start_i while ready_o=0 is ignored (not queued). Input changes after acceptance have no effect.
- ALUResult_o/ALUZero_o are registered and change only in the DONE cycle (or on reset).

Optional Feature:
Macro ALU_SHIFT_FAST_EN.
- Defined:
  - IDLE accepts start_i and goes directly to DONE; the SHIFT state is unused.
  - Result and carry come from a combinational barrel shifter that is bit-exact with the iterative definition, including saturation and the rotate modulo.
  - valid_o is high in cycle N+1 for every k.
- Undefined: iterative behaviour as above. Port list is identical in both builds.

Test Plan:
- WIDTH=8, SHL, A=8'hB3, B=3, fill 0 -> ALUResult_o={1,8'h98}, ALUZero_o=0, valid_o in cycle N+4 (N+1 with FAST).
- SHR, A=8'h0F, B=2, fill 1 -> {1,8'hC3}, valid_o in N+3; start_i pulsed in N+1 is ignored and produces no second valid_o.
- ROL, A=8'h81, B=9 (k=1) -> {1,8'h03}, valid_o in N+2; then ROR, A=8'h01, B=8 (k=0) -> {0,8'h01}, valid_o in N+1.
- SHL, A=8'hFF, B=12, fill 0 (saturate, k=8) -> {1,8'h00}, ALUZero_o=1, valid_o in N+9.
- SHR, A=8'hAA, B=7; assert rst_i in N+3 -> from N+4: ready_o=1, ALUResult_o=0, ALUZero_o=1, no valid_o pulse. A fresh start_i in N+5 completes normally.
- Back-to-back: a new start is accepted in the cycle after DONE. The previous result stays stable until the new DONE cycle.

Source files
------------

// File: rtl/module_alu_shift_seq.sv
// module_alu_shift_seq: sequential shift/rotate unit (SHL/SHR/ROL/ROR) with fill bit, carry and zero flags
// Ports: clk_i/rst_i (sync active-high), start_i accepted while ready_o=1; ALUA_i operand, ALUB_i shift amount,
//        ALUFlagIn_i logical fill bit, ALUMode_i 00 SHL 01 SHR 10 ROL 11 ROR; valid_o one-cycle done pulse,
//        ALUResult_o {carry, result} and ALUZero_o held until the next completion.
// Build option: define ALU_SHIFT_FAST_EN for a single-cycle barrel path instead of one bit per clock.
module module_alu_shift_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] ALUA_i,
  input  logic [CNT_W-1:0] ALUB_i,
  input  logic             ALUFlagIn_i,
  input  logic [1:0]       ALUMode_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH:0]   ALUResult_o,
  output logic             ALUZero_o
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q;
  logic [WIDTH:0]   res_q;
  logic             zero_q;
  logic             valid_q;
  logic             ready_q;
  logic [CNT_W-1:0] k;
  // shifts saturate at WIDTH, rotates wrap modulo WIDTH
  always_comb k = ALUMode_i[1] ? {1'b0, ALUB_i[CNT_W-2:0]}
                : (ALUB_i > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : ALUB_i);
  assign ready_o     = ready_q;
  assign valid_o     = valid_q;
  assign ALUResult_o = res_q;
  assign ALUZero_o   = zero_q;
`ifdef ALU_SHIFT_FAST_EN
  logic [2*WIDTH:0]   shl_w;
  logic [2*WIDTH:0]   shr_w;
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;
  logic [WIDTH:0]     res_d;
  // fill bits sit next to the operand so a single shift reproduces k iterative steps; the guard bit is the carry
  always_comb begin
    shl_w = {1'b0, ALUA_i, {WIDTH{ALUFlagIn_i}}} << k;
    shr_w = {{WIDTH{ALUFlagIn_i}}, ALUA_i, 1'b0} >> k;
    rol_w = {ALUA_i, ALUA_i} << k;
    ror_w = {ALUA_i, ALUA_i} >> k;
    res_d = ALUMode_i == 2'b00 ? {(k != '0) && shl_w[2*WIDTH], shl_w[2*WIDTH-1:WIDTH]}
          : ALUMode_i == 2'b01 ? {(k != '0) && shr_w[0], shr_w[WIDTH:1]}
          : ALUMode_i == 2'b10 ? {(k != '0) && rol_w[WIDTH], rol_w[2*WIDTH-1:WIDTH]}
          :                      {(k != '0) && ror_w[WIDTH-1], ror_w[WIDTH-1:0]};
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        state_q <= DONE;
        res_q   <= res_d;
        zero_q  <= res_d[WIDTH-1:0] == '0;
        valid_q <= 1'b1;
        ready_q <= 1'b0;
      end
    end else begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end
  end
`else
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             carry_q;
  logic             carry_d;
  logic [1:0]       mode_q;
  logic             fill_q;
  logic [CNT_W-1:0] cnt_q;
  // mode bit 0 selects direction, bit 1 selects rotate (wrap) over fill
  always_comb begin
    data_d  = mode_q[0] ? {mode_q[1] ? data_q[0] : fill_q, data_q[WIDTH-1:1]}
            : {data_q[WIDTH-2:0], mode_q[1] ? data_q[WIDTH-1] : fill_q};
    carry_d = mode_q[0] ? data_q[0] : data_q[WIDTH-1];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      mode_q  <= 2'b00;
      fill_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          data_q  <= ALUA_i;
          carry_q <= 1'b0;
          mode_q  <= ALUMode_i;
          fill_q  <= ALUFlagIn_i;
          cnt_q   <= k;
          ready_q <= 1'b0;
          if (k == '0) begin
            state_q <= DONE;
            res_q   <= {1'b0, ALUA_i};
            zero_q  <= ALUA_i == '0;
            valid_q <= 1'b1;
          end else begin
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          data_q  <= data_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= DONE;
            res_q   <= {carry_d, data_d};
            zero_q  <= data_d == '0;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_module_alu_shift_seq.sv
// tb_module_alu_shift_seq: table, hand-sequence and random checks of module_alu_shift_seq against a reference model
module tb_module_alu_shift_seq;
  localparam int W = 8;
  localparam int CW = 4;
`ifdef ALU_SHIFT_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          fill;
  logic [W-1:0]  a;
  logic [CW-1:0] b;
  logic [1:0]    mode;
  logic          ready;
  logic          valid;
  logic [W:0]    res;
  logic          zero;
  logic [W:0]    prev_res;
  int            total = 0;
  int            bad = 0;
  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    bit         fill;
    logic [1:0] mode;
    logic [8:0] res;
    bit         zero;
    int         lat;
  } vec_t;
  vec_t tbl[9];
  always #5 clk = ~clk;
  module_alu_shift_seq #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .ALUA_i(a), .ALUB_i(b),
    .ALUFlagIn_i(fill), .ALUMode_i(mode), .ready_o(ready), .valid_o(valid),
    .ALUResult_o(res), .ALUZero_o(zero)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [7:0] ma, input int mb, input bit mf,
                                       input logic [1:0] mm, output int k);
    longint v = ma;
    longint r;
    longint c;
    k = mm[1] ? mb % W : (mb > W ? W : mb);
    case (mm)
      2'b00: begin
        r = (v << k) | (mf ? (longint'(1) << k) - 1 : 0);
        c = k == 0 ? 0 : (v >> (W - k)) & 1;
      end
      2'b01: begin
        r = (v >> k) | (mf ? ((longint'(1) << k) - 1) << (W - k) : 0);
        c = k == 0 ? 0 : (v >> (k - 1)) & 1;
      end
      2'b10: begin
        r = (v << k) | (v >> (W - k));
        c = k == 0 ? 0 : r & 1;
      end
      default: begin
        r = (v >> k) | (v << (W - k));
        c = k == 0 ? 0 : (r >> (W - 1)) & 1;
      end
    endcase
    return {c[0], r[7:0]};
  endfunction
  task automatic run_op(input logic [7:0] ta, input logic [3:0] tb_, input bit tf, input logic [1:0] tm,
                        input logic [8:0] er, input bit ez, input int elat, input bit extra, input string nm);
    bit got = 1'b0;
    @(negedge clk);
    chk({nm, " idle"}, {30'd0, valid, ready}, 32'd1);
    a = ta;
    b = tb_;
    fill = tf;
    mode = tm;
    start_i = 1'b1;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      start_i = extra && c == 1;
      a = W'($urandom);
      b = CW'($urandom);
      fill = 1'($urandom);
      mode = 2'($urandom);
      chk({nm, " busy"}, {31'd0, ready}, 32'd0);
      if (valid) begin
        got = 1'b1;
        chk({nm, " latency"}, c, elat);
        chk({nm, " result"}, {23'd0, res}, {23'd0, er});
        chk({nm, " zero"}, {31'd0, zero}, {31'd0, ez});
        prev_res = er;
      end else begin
        chk({nm, " hold"}, {23'd0, res}, {23'd0, prev_res});
      end
    end
    if (!got) chk({nm, " timeout"}, 32'd0, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    logic [7:0] ra;
    logic [3:0] rb;
    bit rf;
    logic [1:0] rm;
    logic [8:0] er;
    tbl[0] = '{8'hB3, 4'd3,  1'b0, 2'b00, 9'h198, 1'b0, 4};
    tbl[1] = '{8'h0F, 4'd2,  1'b1, 2'b01, 9'h1C3, 1'b0, 3};
    tbl[2] = '{8'h81, 4'd9,  1'b0, 2'b10, 9'h103, 1'b0, 2};
    tbl[3] = '{8'h01, 4'd8,  1'b0, 2'b11, 9'h001, 1'b0, 1};
    tbl[4] = '{8'hFF, 4'd12, 1'b0, 2'b00, 9'h100, 1'b1, 9};
    tbl[5] = '{8'hAA, 4'd7,  1'b0, 2'b01, 9'h001, 1'b0, 8};
    tbl[6] = '{8'h01, 4'd1,  1'b1, 2'b11, 9'h180, 1'b0, 2};
    tbl[7] = '{8'h80, 4'd15, 1'b1, 2'b01, 9'h1FF, 1'b0, 9};
    tbl[8] = '{8'h00, 4'd0,  1'b1, 2'b00, 9'h000, 1'b1, 1};
    rst = 1'b1;
    start_i = 1'b1;
    a = 8'h5A;
    b = 4'd1;
    fill = 1'b0;
    mode = 2'b00;
    prev_res = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset ready", {31'd0, ready}, 32'd1);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset result", {23'd0, res}, 32'd0);
    chk("reset zero", {31'd0, zero}, 32'd1);
    rst = 1'b0;
    start_i = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].fill, tbl[i].mode, tbl[i].res, tbl[i].zero,
             FAST ? 1 : tbl[i].lat, i == 1, $sformatf("vec%0d", i));
      if (i == 1) begin
        repeat (4) begin
          @(negedge clk);
          start_i = 1'b0;
          chk("ignored start valid", {31'd0, valid}, 32'd0);
          chk("ignored start ready", {31'd0, ready}, 32'd1);
        end
      end
    end
    @(negedge clk);
    a = 8'hAA;
    b = 4'd7;
    fill = 1'b0;
    mode = 2'b01;
    start_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 3) rst = 1'b1;
      if (c == 4) begin
        rst = 1'b0;
        chk("abort ready", {31'd0, ready}, 32'd1);
        chk("abort result", {23'd0, res}, 32'd0);
        chk("abort zero", {31'd0, zero}, 32'd1);
        chk("abort valid", {31'd0, valid}, 32'd0);
      end else if (c > 1) begin
        chk("abort no pulse", {31'd0, valid}, 32'd0);
      end
    end
    prev_res = '0;
    run_op(8'hAA, 4'd7, 1'b0, 2'b01, 9'h001, 1'b0, FAST ? 1 : 8, 1'b0, "after abort");
    repeat (40) begin
      ra = 8'($urandom);
      rb = 4'($urandom);
      rf = 1'($urandom);
      rm = 2'($urandom);
      er = model(ra, int'(rb), rf, rm, k);
      run_op(ra, rb, rf, rm, er, er[7:0] == 8'h00, FAST ? 1 : k + 1, 1'b0, "random");
    end
    @(negedge clk);
    chk("final idle", {30'd0, valid, ready}, 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
